load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Memory-stage access controller between the execute stage and the word-wide data memory
//   (sync write, async read, Mem_Read/Mem_Write strobes).
//   Accepts byte/half/word load and store requests on a valid/ready handshake.
//   Performs alignment checks and sign/zero extension, and does read-modify-write for sub-word stores.
//   Returns one response pulse per request.
// PARAMETERS
//   DATA_WIDTH  32  memory word width; only 32 is supported (elaboration error otherwise)
//   ADDR_WIDTH  8   memory word-address width (2^ADDR_WIDTH words)
// PORTS
//   clk             in   1           single clock, rising edge
//   rst             in   1           asynchronous, active-high reset
//   Req_Valid       in   1           request present
//   Req_Ready       out  1           high only in IDLE; transfer = Req_Valid & Req_Ready at posedge
//   Req_Write       in   1           1 = store, 0 = load
//   Req_Size        in   2           00 byte, 01 half, 10 word, 11 illegal
//   Req_Unsigned    in   1           loads: 1 = zero-extend, 0 = sign-extend
//   Req_Addr        in   32          byte address, little-endian
//   Req_Wdata       in   32          store data; byte/half taken from the low bits
//   Resp_Valid      out  1           one-cycle completion pulse
//   Resp_Rdata      out  32          extended load data; 0 for stores and faults
//   Resp_Fault      out  1           valid with Resp_Valid; misaligned/illegal/out-of-range
//   Mem_Address     out  ADDR_WIDTH  word address = Req_Addr[ADDR_WIDTH+1:2]
//   Mem_Write_Data  out  DATA_WIDTH  word to write
//   Mem_Write       out  1           memory write strobe
//   Mem_Read        out  1           memory read strobe
//   Mem_Read_Data   in   DATA_WIDTH  async read data from memory
// BEHAVIOUR
// - Reset (async): state=IDLE. Resp_Valid=0, Resp_Rdata=0, Resp_Fault=0. All Mem_* outputs=0.
//   Request latches are cleared.
// - FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
//   Mem_* outputs decode from the state and the latched request; they are 0 in IDLE and RESP.
// - IDLE, on transfer: latch the request, then go to:
//   - RESP with fault if any of: Req_Size==11; half with Addr[0]=1; word with Addr[1:0]!=0;
//     Addr[31:ADDR_WIDTH+2]!=0.
//   - LOAD for a valid load.
//   - WRITE for a valid word store.
//   - RMW_RD for a valid byte/half store.
// - LOAD: Mem_Read=1. Extract the lane by Addr[1:0] and size, extend, and register into
//   Resp_Rdata at the edge. Next state RESP.
// - RMW_RD: Mem_Read=1. Merge the store byte/half into the read word at lane Addr[1:0] and
//   register it in the merge buffer. Next state WRITE.
// - WRITE: Mem_Write=1. Mem_Write_Data = Req_Wdata (word) or merge buffer (sub-word).
//   Write happens at this edge. Next state RESP.
// - RESP: Resp_Valid=1 for exactly one cycle; no backpressure. Next state IDLE.
//   Resp_Rdata/Resp_Fault hold until the next response.
// - Latency, from accept edge to Resp_Valid high:
//   fault 1 cycle; load 2; word store 2; sub-word store 3.
//   Throughput is one request per (latency+1) cycles.
// - Faults never assert Mem_Read or Mem_Write.
// - Req_Valid while busy is ignored (Req_Ready=0). The requester holds its request.
// - Reset asserted in WRITE drops Mem_Write asynchronously, so that write is suppressed.
//   Reset in any other state aborts with no memory side effect and no response.
// - Sign extension uses bit 7 (byte) or bit 15 (half) of the extracted lane.
// STRUCTURE
// - lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, fault check function.
// - Sub-module lsu_align (combinational): lane extract+extend for loads, lane merge for stores.
//   Instantiated once; the FSM and registers live in load_store_unit.
// TESTING
// - LW addr 0x10, mem[4]=0xDEADBEEF -> Mem_Read in cycle 1, Resp_Valid cycle 2,
//   Rdata=0xDEADBEEF, Fault=0.
// - LB signed addr 0x13, mem[4]=0x80FF0011 -> Rdata=0xFFFFFF80.
//   LBU same address -> 0x00000080. LHU addr 0x12 -> 0x000080FF.
// - SB addr 0x21, data 0xAB, mem[8]=0x11223344 -> RMW_RD then WRITE.
//   mem[8]=0x1122AB44, Resp_Valid at cycle 3.
// - Faults -> Resp_Fault=1 at cycle 1, Mem_Read/Mem_Write never high:
//   LH addr 0x01; SW addr 0x06; Size=11; LW addr 0x400 (ADDR_WIDTH=8).
// - Back-to-back requests with Req_Valid held -> Req_Ready low in non-IDLE states.
//   Second request is accepted only in IDLE after RESP; both complete in order.
// - rst pulsed during WRITE of SW 0x30 data 0x55 -> mem[12] unchanged, no Resp_Valid,
//   all outputs 0, Req_Ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and request fault check for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  // Illegal size, misaligned half/word, or byte address beyond the memory.
  function automatic logic fault_check(input logic [1:0] size, input logic [31:0] addr,
                                       input int addr_width);
    logic f;
    f = 1'b0;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = addr[0];
      SZ_WORD: f = (addr[1:0] != 2'b00);
      default: f = 1'b1;
    endcase
    f = f | ((addr >> (addr_width + 2)) != 32'd0);
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Load path: pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_lane = word[{lane, 3'b000} +: 8];
    half_lane = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

  // Store path: overlay the low bits of the store data onto the addressed lane.
  always_comb begin
    merge_data = word;
    case (size)
      SZ_BYTE: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: handshake, alignment faults, sub-word read-modify-write,
// one response pulse per accepted request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Req_Size,
  input  logic                  Req_Unsigned,
  input  logic [31:0]           Req_Addr,
  input  logic [31:0]           Req_Wdata,
  output logic                  Resp_Valid,
  output logic [31:0]           Resp_Rdata,
  output logic                  Resp_Fault,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic                  Mem_Write,
  output logic                  Mem_Read,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("load_store_unit supports DATA_WIDTH=32 only");
  end

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] merge_buf;
  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign Req_Ready = (state == ST_IDLE);
  assign req_fault = fault_check(Req_Size, Req_Addr, ADDR_WIDTH);

  lsu_align u_align (
    .word        (Mem_Read_Data),
    .lane        (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // State register; reset returns to IDLE asynchronously, which also drops any write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Req_Valid) begin
          if (req_fault) begin
            state_next = ST_RESP;
          end else if (!Req_Write) begin
            state_next = ST_LOAD;
          end else if (Req_Size == SZ_WORD) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_RMW_RD;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD:   state_next = ST_RESP;
      ST_RMW_RD: state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory strobes follow the state and the latched request; quiet in IDLE and RESP.
  always_comb begin
    Mem_Read       = 1'b0;
    Mem_Write      = 1'b0;
    Mem_Address    = '0;
    Mem_Write_Data = '0;
    case (state)
      ST_LOAD, ST_RMW_RD: begin
        Mem_Read    = 1'b1;
        Mem_Address = req_addr[ADDR_WIDTH+1:2];
      end
      ST_WRITE: begin
        Mem_Write      = 1'b1;
        Mem_Address    = req_addr[ADDR_WIDTH+1:2];
        Mem_Write_Data = (req_size == SZ_WORD) ? req_wdata : merge_buf;
      end
      default: begin
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
      end
    endcase
  end

  // Request latches, merge buffer and response registers; response fields change only when
  // entering RESP so they hold across the next request's busy period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_write    <= 1'b0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      merge_buf    <= 32'd0;
      Resp_Valid   <= 1'b0;
      Resp_Rdata   <= 32'd0;
      Resp_Fault   <= 1'b0;
    end else begin
      Resp_Valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Req_Valid) begin
            req_write    <= Req_Write;
            req_size     <= Req_Size;
            req_unsigned <= Req_Unsigned;
            req_addr     <= Req_Addr;
            req_wdata    <= Req_Wdata;
            if (req_fault) begin
              Resp_Valid <= 1'b1;
              Resp_Rdata <= 32'd0;
              Resp_Fault <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          Resp_Valid <= 1'b1;
          Resp_Rdata <= load_data;
          Resp_Fault <= 1'b0;
        end
        ST_RMW_RD: merge_buf <= merge_data;
        ST_WRITE: begin
          Resp_Valid <= 1'b1;
          Resp_Rdata <= 32'd0;
          Resp_Fault <= 1'b0;
        end
        default: Resp_Valid <= 1'b0;
      endcase
    end
  end

endmodule
